uart_tx_fifo: RTL and testbench

- Byte buffer and dispatcher that sits directly upstream of the UART transmitter.
- Accepts bytes from the system side at any rate and stores them in a synchronous FIFO.
- Drives the transmitter's data/send/ready handshake so queued bytes go out back-to-back, in order, without host polling.
- Everything runs on clk; the transmitter's ready is synchronised before use.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | Package : uart_pkg                                           |
// | Dispatcher state encoding and counter width helper.          |
// | Rev     : 1.0                                                |
// +--------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_t;

   // Bits needed to hold the values 0..n inclusive (n a power of two).
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------+
// | Module : sync_fifo                                           |
// | Byte FIFO with flush and simultaneous push/pop at full.      |
// | Rev    : 1.0                                                 |
// +--------------------------------------------------------------+
module sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   input  logic                     pop,
   input  logic                     flush,
   input  logic                     keep_head,
   output logic [7:0]               head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_one  = (AW+1)'(1);
   localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

   logic [AW:0] r_wr_cnt;
   logic [AW:0] r_rd_cnt;
   logic [7:0]  r_mem [DEPTH];
   logic        w_push;

   assign level     = r_wr_cnt - r_rd_cnt;
   assign full      = (level == c_full);
   assign empty     = (level == '0);
   assign head_data = r_mem[r_rd_cnt[AW-1:0]];

   // A pop frees the slot the push needs, so a full FIFO still accepts then.
   assign w_push  = wr_en & ~flush & (~full | pop);
   assign dropped = wr_en & ~flush & full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
      end else begin
         if (pop)
            r_rd_cnt <= r_rd_cnt + c_one;
         if (flush)
            r_wr_cnt <= r_rd_cnt + {{AW{1'b0}}, keep_head};
         else if (w_push)
            r_wr_cnt <= r_wr_cnt + c_one;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_cnt[AW-1:0]] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------+
// | Module : uart_tx_fifo                                        |
// | Byte buffer and send dispatcher ahead of the UART TX.        |
// | Rev    : 1.0                                                 |
// +--------------------------------------------------------------+
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int BUSY_TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   input  logic                     flush,
   input  logic                     clr_ovf,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               tx_data,
   output logic                     tx_send,
   input  logic                     tx_ready,
   output logic                     busy
);

   localparam int TW = cnt_width(BUSY_TIMEOUT);
   localparam logic [TW-1:0] c_tmo_last = TW'(BUSY_TIMEOUT - 1);
   localparam logic [TW-1:0] c_tmo_one  = TW'(1);

   tx_state_t              r_state;
   tx_state_t              w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [TW-1:0]          r_tmo;
   logic [7:0]             r_tx_data;
   logic                   r_ovf;
   logic [7:0]             w_head;
   logic                   w_rdy_s;
   logic                   w_launch;
   logic                   w_pop;
   logic                   w_keep;
   logic                   w_dropped;

   sync_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .pop       (w_pop),
      .flush     (flush),
      .keep_head (w_keep),
      .head_data (w_head),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .dropped   (w_dropped)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync[0] <= tx_ready;
         for (int i = 1; i < SYNC_STAGES; i++)
            r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_rdy_s  = r_sync[SYNC_STAGES-1];
   assign w_launch = (r_state == IDLE) & ~empty;
   assign w_pop    = (r_state == WAIT_DONE) & w_rdy_s;
   // A byte being launched this very cycle must survive a concurrent flush,
   // otherwise its later pop would underflow the pointers.
   assign w_keep   = busy | w_launch;

   assign busy     = (r_state != IDLE);
   assign tx_send  = (r_state == SEND);
   assign tx_data  = r_tx_data;
   assign overflow = r_ovf;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:      if (!empty) w_state_nxt = SEND;
         SEND:      w_state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!w_rdy_s)
               w_state_nxt = WAIT_DONE;
            else if (r_tmo == c_tmo_last)
               w_state_nxt = SEND;
         end
         WAIT_DONE: if (w_rdy_s) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_tx_data <= 8'h00;
         r_tmo     <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_launch)
            r_tx_data <= w_head;
         if (r_state == SEND)
            r_tmo <= '0;
         else if (r_state == WAIT_BUSY)
            r_tmo <= r_tmo + c_tmo_one;
         if (w_dropped)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// Randomised and directed bench for uart_tx_fifo with a queue-based
// reference model and a transmitter model driving tx_ready.
module tb_uart_tx_fifo;

   localparam int DEPTH = 8;
   localparam int SYNC  = 2;
   localparam int TMO   = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       flush = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       full, empty, overflow, tx_send, busy;
   logic [3:0] level;
   logic [7:0] tx_data;
   logic       tx_ready = 1'b1;

   uart_tx_fifo #(
      .DEPTH        (DEPTH),
      .SYNC_STAGES  (SYNC),
      .BUSY_TIMEOUT (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .flush    (flush),
      .clr_ovf  (clr_ovf),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .tx_data  (tx_data),
      .tx_send  (tx_send),
      .tx_ready (tx_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h at cycle", name, act, exp);
      end
   endtask

   // Reference model state: bytes held by the FIFO, front is the in-flight one.
   logic [7:0] exp_q[$];
   bit         in_flight = 0;
   int         pop_cd = 0;
   bit         m_ovf = 0;
   bit         pop_now, acc, drop;
   int         cyc = 0;

   // Transmitter model controls.
   bit         hold_low = 0;
   bit         stuck = 0;
   int         frame_len = 200;
   bit         frame_act = 0;
   int         frame_cnt = 0;
   bit         nxt_rdy;
   int         send_cnt = 0;
   int         send_cyc[$];

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         in_flight = 0;
         pop_cd    = 0;
         m_ovf     = 0;
      end else begin
         pop_now = 0;
         if (pop_cd > 0) begin
            pop_cd--;
            pop_now = (pop_cd == 0);
         end
         acc  = wr_en && !flush && (exp_q.size() < DEPTH || pop_now);
         drop = wr_en && !flush && exp_q.size() >= DEPTH && !pop_now;
         if (pop_now) begin
            void'(exp_q.pop_front());
            in_flight = 0;
         end
         if (flush)
            while (exp_q.size() > int'(in_flight)) void'(exp_q.pop_back());
         if (acc)
            exp_q.push_back(wr_data);
         if (drop)
            m_ovf = 1;
         else if (clr_ovf)
            m_ovf = 0;
      end
   end

   // Monitor/scoreboard plus transmitter model, evaluated mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         tx_ready  = 1'b1;
         frame_act = 0;
         frame_cnt = 0;
      end else begin
         if (tx_send) begin
            send_cnt++;
            send_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL send_data: send with no queued byte, tx_data 0x%0h", tx_data);
            end else begin
               check("send_data", tx_data, exp_q[0]);
            end
            if (!stuck) begin
               check("dup_send", frame_act, 0);
               if (!frame_act) begin
                  frame_act = 1;
                  frame_cnt = 0;
               end
            end
            in_flight = 1;
         end else if (in_flight && exp_q.size() != 0) begin
            check("tx_data_stable", tx_data, exp_q[0]);
         end
         check("level", level, exp_q.size());
         check("empty", empty, exp_q.size() == 0);
         check("full", full, exp_q.size() == DEPTH);
         check("overflow", overflow, m_ovf);
         check("busy", busy, in_flight);
         if (frame_act) begin
            frame_cnt++;
            if (frame_cnt >= frame_len) frame_act = 0;
         end
         nxt_rdy = !(hold_low || (frame_act && frame_cnt >= 4));
         if (nxt_rdy && !tx_ready && in_flight)
            pop_cd = SYNC + 1;
         tx_ready = nxt_rdy;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || in_flight) && n < bound) begin
         tick();
         n++;
      end
      check("drain_in_time", n < bound, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, n, base;

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_level", level, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_tx_send", tx_send, 0);
      check("rst_tx_data", tx_data, 8'h00);

      // Single byte and launch latency.
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      check("lat_empty_n1", empty, 0);
      check("lat_send_n1", tx_send, 0);
      tick();
      check("lat_send_n2", tx_send, 1);
      check("lat_data_n2", tx_data, 8'hA5);
      tick();
      check("send_one_cycle", tx_send, 0);
      wait_drain(400);
      tick(); tick();
      check("single_send_count", send_cnt, 1);
      check("single_busy_idle", busy, 0);

      // Overflow, then push on the exact pop cycle at full.
      frame_len = 30;
      hold_low  = 1;
      tick(); tick();
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
      end
      wr_en = 1'b0;
      check("ovf_set", overflow, 1);
      check("ovf_full", full, 1);
      check("ovf_level", level, 8);
      repeat (40) tick();
      hold_low = 0;
      n = 0;
      while (pop_cd != 1 && n < 100) begin
         tick();
         n++;
      end
      check("pop_seen", n < 100, 1);
      wr_en = 1'b1; wr_data = 8'h55;
      tick();
      wr_en = 1'b0;
      check("pushpop_level", level, 8);
      check("pushpop_ovf_kept", overflow, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      wait_drain(2000);

      // Timeout retry with tx_ready stuck high.
      stuck = 1;
      send_cyc.delete();
      wr_en = 1'b1; wr_data = 8'h3C;
      tick();
      wr_en = 1'b0;
      n = 0;
      while (send_cyc.size() < 3 && n < 200) begin
         tick();
         n++;
      end
      check("retry_seen", send_cyc.size() >= 3, 1);
      if (send_cyc.size() >= 3) begin
         check("retry_gap1", send_cyc[1] - send_cyc[0], TMO + 1);
         check("retry_gap2", send_cyc[2] - send_cyc[1], TMO + 1);
      end
      check("retry_level", level, 1);
      stuck = 0;
      wait_drain(400);

      // Flush while the first of five bytes is in flight.
      hold_low = 1;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      repeat (12) tick();
      check("preflush_level", level, 5);
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      check("flush_level", level, 1);
      check("flush_no_ovf", overflow, 0);
      sc = send_cnt;
      hold_low = 0;
      wait_drain(400);
      repeat (30) tick();
      check("flush_no_more_send", send_cnt, sc);
      check("flush_empty", empty, 1);

      // Asynchronous reset in the middle of a frame.
      frame_len = 40;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      repeat (10) tick();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_level", level, 0);
      check("arst_empty", empty, 1);
      check("arst_tx_send", tx_send, 0);
      check("arst_busy", busy, 0);
      check("arst_tx_data", tx_data, 8'h00);
      tick(); tick();
      rst = 1'b0;
      sc = send_cnt;
      repeat (20) tick();
      check("arst_no_send", send_cnt, sc);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         frame_len = $urandom_range(20, 60);
         wr_en     = ($urandom_range(0, 3) == 0);
         wr_data   = 8'($urandom);
         clr_ovf   = ($urandom_range(0, 31) == 0);
         tick();
      end
      wr_en = 1'b0; clr_ovf = 1'b0;
      wait_drain(3000);
      base = send_cnt;
      repeat (10) tick();
      check("final_no_send", send_cnt, base);
      check("final_empty", empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
